// File: rtl/trace_stream_fifo_if.sv
// Stream handshake bundle for trace_stream_fifo.
// Holds the producer-side (S_AXIS_*) and consumer-side (M_AXIS_*) signals.
//   slave  : view taken by the FIFO (accepts S_AXIS, drives M_AXIS)
//   master : view taken by the surrounding fabric / testbench
interface trace_stream_fifo_if #(
    parameter int DATA_W = 32
);
    logic              S_AXIS_TVALID;
    logic              S_AXIS_TREADY;
    logic [DATA_W-1:0] S_AXIS_TDATA;
    logic              M_AXIS_TVALID;
    logic              M_AXIS_TREADY;
    logic [DATA_W-1:0] M_AXIS_TDATA;

    modport slave (
        input  S_AXIS_TVALID,
        input  S_AXIS_TDATA,
        output S_AXIS_TREADY,
        output M_AXIS_TVALID,
        output M_AXIS_TDATA,
        input  M_AXIS_TREADY
    );

    modport master (
        output S_AXIS_TVALID,
        output S_AXIS_TDATA,
        input  S_AXIS_TREADY,
        input  M_AXIS_TVALID,
        input  M_AXIS_TDATA,
        output M_AXIS_TREADY
    );
endinterface

// File: rtl/trace_stream_fifo.sv
// First-word-fall-through FIFO buffering trace words from the monitor fabric
// ahead of the AXI-mapped FIFO register block.
// Ports:
//   AXI_ACLK      clock
//   AXI_ARESET    synchronous active-high reset
//   axis          stream bundle (S_AXIS producer side, M_AXIS FWFT consumer side)
//   M_AXIS_count  registered occupancy, zero-extended
//   drop_count    words discarded while full (saturating, drop mode only)
//   high_water    peak occupancy since reset or last clear_stats
//   clear_stats   one-cycle pulse: zero drop_count, reload high_water
module trace_stream_fifo #(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 512,
    parameter bit DROP_ON_FULL = 1'b1
) (
    input  logic                AXI_ACLK,
    input  logic                AXI_ARESET,
    trace_stream_fifo_if.slave  axis,
    output logic [31:0]         M_AXIS_count,
    output logic [31:0]         drop_count,
    output logic [31:0]         high_water,
    input  logic                clear_stats
);
    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [AW:0]       count_next;
    logic [AW:0]       hw_q;
    logic              full;
    logic              empty;
    logic              pop;
    logic              store;
    logic              drop;
    logic              s_ready;

    always_comb begin
        full  = (count == FULL_COUNT);
        empty = (count == '0);
        pop   = ~empty & axis.M_AXIS_TREADY;
        if (DROP_ON_FULL) begin
            // Always ready; a word arriving while full is only kept if the
            // head leaves in the same cycle, otherwise it is counted as dropped.
            s_ready = ~AXI_ARESET;
            store   = axis.S_AXIS_TVALID & s_ready & (~full | pop);
            drop    = axis.S_AXIS_TVALID & s_ready & full & ~pop;
        end else begin
            // Ready comes from the registered count only, so no path from
            // M_AXIS_TREADY reaches S_AXIS_TREADY.
            s_ready = ~AXI_ARESET & ~full;
            store   = axis.S_AXIS_TVALID & s_ready;
            drop    = 1'b0;
        end
        count_next = count + (AW+1)'(store) - (AW+1)'(pop);
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_count <= '0;
            hw_q       <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;

            // A clear coincident with a drop wins; that drop is not counted.
            if (clear_stats) begin
                drop_count <= '0;
            end else if (drop && (drop_count != '1)) begin
                drop_count <= drop_count + 32'd1;
            end

            if (clear_stats || (count_next > hw_q)) begin
                hw_q <= count_next;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge AXI_ACLK) begin
        if (store) begin
            mem[wr_ptr] <= axis.S_AXIS_TDATA;
        end
    end

    assign axis.S_AXIS_TREADY = s_ready;
    assign axis.M_AXIS_TVALID = ~empty;
    assign axis.M_AXIS_TDATA  = mem[rd_ptr];
    assign M_AXIS_count       = 32'(count);
    assign high_water         = 32'(hw_q);
endmodule

// File: tb/tb_trace_stream_fifo.sv
// Directed bench for trace_stream_fifo: a default-size drop-mode instance (a),
// a DEPTH=4 drop-mode instance (d) and a DEPTH=4 backpressure instance (b).
module tb_trace_stream_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    trace_stream_fifo_if #(.DATA_W(32)) ifa ();
    trace_stream_fifo_if #(.DATA_W(32)) ifd ();
    trace_stream_fifo_if #(.DATA_W(32)) ifb ();

    logic [31:0] cnt_a, drop_a, hw_a;
    logic [31:0] cnt_d, drop_d, hw_d;
    logic [31:0] cnt_b, drop_b, hw_b;
    logic        clr_a = 1'b0;
    logic        clr_d = 1'b0;
    logic        clr_b = 1'b0;

    trace_stream_fifo dut_a (
        .AXI_ACLK(clk), .AXI_ARESET(rst), .axis(ifa.slave),
        .M_AXIS_count(cnt_a), .drop_count(drop_a), .high_water(hw_a),
        .clear_stats(clr_a)
    );

    trace_stream_fifo #(.DEPTH(4), .DROP_ON_FULL(1'b1)) dut_d (
        .AXI_ACLK(clk), .AXI_ARESET(rst), .axis(ifd.slave),
        .M_AXIS_count(cnt_d), .drop_count(drop_d), .high_water(hw_d),
        .clear_stats(clr_d)
    );

    trace_stream_fifo #(.DEPTH(4), .DROP_ON_FULL(1'b0)) dut_b (
        .AXI_ACLK(clk), .AXI_ARESET(rst), .axis(ifb.slave),
        .M_AXIS_count(cnt_b), .drop_count(drop_b), .high_water(hw_b),
        .clear_stats(clr_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ifa.S_AXIS_TVALID = 0; ifa.S_AXIS_TDATA = 0; ifa.M_AXIS_TREADY = 0;
        ifd.S_AXIS_TVALID = 0; ifd.S_AXIS_TDATA = 0; ifd.M_AXIS_TREADY = 0;
        ifb.S_AXIS_TVALID = 0; ifb.S_AXIS_TDATA = 0; ifb.M_AXIS_TREADY = 0;

        // Reset state
        tick(); tick();
        check_eq("rst_count", cnt_a, 32'd0);
        check_eq("rst_tvalid", 32'(ifa.M_AXIS_TVALID), 32'd0);
        check_eq("rst_tready_held", 32'(ifa.S_AXIS_TREADY), 32'd0);
        check_eq("rst_drop", drop_a, 32'd0);
        check_eq("rst_hw", hw_a, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("rel_tready_a", 32'(ifa.S_AXIS_TREADY), 32'd1);
        check_eq("rel_tready_b", 32'(ifb.S_AXIS_TREADY), 32'd1);

        // Push 1..5 back-to-back, no pops
        for (int i = 1; i <= 5; i++) begin
            ifa.S_AXIS_TVALID = 1'b1;
            ifa.S_AXIS_TDATA  = 32'(i);
            if (i == 1) check_eq("tvalid_before_first", 32'(ifa.M_AXIS_TVALID), 32'd0);
            tick();
            if (i == 1) begin
                check_eq("tvalid_latency", 32'(ifa.M_AXIS_TVALID), 32'd1);
                check_eq("head_first", ifa.M_AXIS_TDATA, 32'd1);
            end
        end
        ifa.S_AXIS_TVALID = 1'b0;
        check_eq("fill5_count", cnt_a, 32'd5);
        check_eq("fill5_head", ifa.M_AXIS_TDATA, 32'd1);
        check_eq("fill5_hw", hw_a, 32'd5);

        // Pulsed pops, one every 3 cycles
        for (int k = 0; k < 5; k++) begin
            check_eq("pulse_data", ifa.M_AXIS_TDATA, 32'(k + 1));
            ifa.M_AXIS_TREADY = 1'b1;
            tick();
            ifa.M_AXIS_TREADY = 1'b0;
            check_eq("pulse_count", cnt_a, 32'(4 - k));
            tick(); tick();
        end
        check_eq("drained_tvalid", 32'(ifa.M_AXIS_TVALID), 32'd0);
        ifa.M_AXIS_TREADY = 1'b1;
        tick();
        ifa.M_AXIS_TREADY = 1'b0;
        check_eq("empty_pop_count", cnt_a, 32'd0);
        check_eq("empty_pop_tvalid", 32'(ifa.M_AXIS_TVALID), 32'd0);
        check_eq("drained_hw", hw_a, 32'd5);

        // Drop mode, DEPTH=4: 6 words, no pops
        for (int i = 1; i <= 6; i++) begin
            ifd.S_AXIS_TVALID = 1'b1;
            ifd.S_AXIS_TDATA  = 32'(i);
            tick();
        end
        ifd.S_AXIS_TVALID = 1'b0;
        check_eq("drop_count_full", cnt_d, 32'd4);
        check_eq("drop_drops", drop_d, 32'd2);
        check_eq("drop_hw", hw_d, 32'd4);
        check_eq("drop_head", ifd.M_AXIS_TDATA, 32'd1);

        // Full with simultaneous push and pop
        ifd.S_AXIS_TVALID = 1'b1;
        ifd.S_AXIS_TDATA  = 32'hA5A5_A5A5;
        ifd.M_AXIS_TREADY = 1'b1;
        tick();
        ifd.S_AXIS_TVALID = 1'b0;
        ifd.M_AXIS_TREADY = 1'b0;
        check_eq("swap_count", cnt_d, 32'd4);
        check_eq("swap_drops", drop_d, 32'd2);
        ifd.M_AXIS_TREADY = 1'b1;
        check_eq("drain_d0", ifd.M_AXIS_TDATA, 32'd2);
        tick();
        check_eq("drain_d1", ifd.M_AXIS_TDATA, 32'd3);
        tick();
        check_eq("drain_d2", ifd.M_AXIS_TDATA, 32'd4);
        tick();
        check_eq("drain_d3", ifd.M_AXIS_TDATA, 32'hA5A5_A5A5);
        tick();
        ifd.M_AXIS_TREADY = 1'b0;
        check_eq("drain_d_count", cnt_d, 32'd0);
        check_eq("drain_d_tvalid", 32'(ifd.M_AXIS_TVALID), 32'd0);

        // Refill, then clear_stats coincident with a drop
        for (int i = 0; i < 4; i++) begin
            ifd.S_AXIS_TVALID = 1'b1;
            ifd.S_AXIS_TDATA  = 32'h21 + 32'(i);
            tick();
        end
        ifd.S_AXIS_TDATA = 32'h99;
        clr_d = 1'b1;
        tick();
        clr_d = 1'b0;
        check_eq("clear_drop", drop_d, 32'd0);
        check_eq("clear_hw", hw_d, 32'd4);
        tick();
        ifd.S_AXIS_TVALID = 1'b0;
        check_eq("post_clear_drop", drop_d, 32'd1);
        check_eq("post_clear_head", ifd.M_AXIS_TDATA, 32'h21);

        // Backpressure mode, DEPTH=4
        for (int i = 0; i < 4; i++) begin
            ifb.S_AXIS_TVALID = 1'b1;
            ifb.S_AXIS_TDATA  = 32'h31 + 32'(i);
            tick();
        end
        check_eq("bp_full_count", cnt_b, 32'd4);
        check_eq("bp_full_tready", 32'(ifb.S_AXIS_TREADY), 32'd0);
        ifb.S_AXIS_TDATA = 32'h55;
        tick();
        check_eq("bp_hold_count", cnt_b, 32'd4);
        ifb.M_AXIS_TREADY = 1'b1;
        tick();
        ifb.M_AXIS_TREADY = 1'b0;
        check_eq("bp_pop_count", cnt_b, 32'd3);
        check_eq("bp_pop_tready", 32'(ifb.S_AXIS_TREADY), 32'd1);
        tick();
        ifb.S_AXIS_TVALID = 1'b0;
        check_eq("bp_accept_count", cnt_b, 32'd4);
        check_eq("bp_refull_tready", 32'(ifb.S_AXIS_TREADY), 32'd0);
        ifb.M_AXIS_TREADY = 1'b1;
        check_eq("bp_drain0", ifb.M_AXIS_TDATA, 32'h32);
        tick();
        check_eq("bp_drain1", ifb.M_AXIS_TDATA, 32'h33);
        tick();
        check_eq("bp_drain2", ifb.M_AXIS_TDATA, 32'h34);
        tick();
        check_eq("bp_drain3", ifb.M_AXIS_TDATA, 32'h55);
        tick();
        ifb.M_AXIS_TREADY = 1'b0;
        check_eq("bp_empty", cnt_b, 32'd0);
        check_eq("bp_drop", drop_b, 32'd0);

        // Reset with 3 words queued
        for (int i = 0; i < 3; i++) begin
            ifa.S_AXIS_TVALID = 1'b1;
            ifa.S_AXIS_TDATA  = 32'h71 + 32'(i);
            tick();
        end
        ifa.S_AXIS_TVALID = 1'b0;
        check_eq("pre_rst_count", cnt_a, 32'd3);
        rst = 1'b1;
        tick();
        check_eq("mid_rst_count", cnt_a, 32'd0);
        check_eq("mid_rst_tvalid", 32'(ifa.M_AXIS_TVALID), 32'd0);
        check_eq("mid_rst_tready", 32'(ifa.S_AXIS_TREADY), 32'd0);
        check_eq("mid_rst_drop_d", drop_d, 32'd0);
        check_eq("mid_rst_hw_d", hw_d, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_tready", 32'(ifa.S_AXIS_TREADY), 32'd1);
        ifa.M_AXIS_TREADY = 1'b1;
        tick(); tick(); tick();
        ifa.M_AXIS_TREADY = 1'b0;
        check_eq("post_rst_tvalid", 32'(ifa.M_AXIS_TVALID), 32'd0);
        check_eq("post_rst_count", cnt_a, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
